// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared encodings for the multicycle MIPS control path.
//   State codes, opcode constants and ALUOp codes used by multicycle_control
//   and by the ALU control decoder (alu_ctrl helper below).
// Optional feature macro: MULTICYCLE_CONTROL_JUMP_EN adds the JUMP state and
//   the j opcode; without it state 11 does not exist and j decodes as illegal.
package mips_ctrl_pkg;

  // FSM state codes (also exported on the debug 'state' port)
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    ,S_JUMP    = 4'd11
`endif
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;  // sign-extended imm << 2

  // PC source select
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;  // registered ALUOut (branch target)
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // ALU operation codes produced by the ALU control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU control decoder: ALUOp from the main FSM plus instruction funct field.
  function automatic logic [3:0] alu_ctrl(input logic [1:0] aluop,
                                          input logic [5:0] funct);
    logic [3:0] r;
    r = ALU_ADD;
    case (aluop)
      ALUOP_ADD: r = ALU_ADD;
      ALUOP_SUB: r = ALU_SUB;
      default: begin
        case (funct)
          6'b100000: r = ALU_ADD;
          6'b100010: r = ALU_SUB;
          6'b100100: r = ALU_AND;
          6'b100101: r = ALU_OR;
          6'b101010: r = ALU_SLT;
          default:   r = ALU_ADD;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control -- Moore control FSM for a multicycle MIPS datapath.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     opcode[5:0]       instruction opcode, sampled and latched in DECODE
//     mem_ready         memory handshake; access completes in the cycle it is 1
//     IRWrite..RegWrite single-bit datapath controls
//     ALUSrcB, PCSrc, ALUOp  2-bit datapath selects
//     illegal           one-cycle pulse on unsupported opcode in DECODE
//     retired[CNT_W-1:0] count of completed instructions (wraps)
//     state[3:0]        current state code, debug only
//   Optional feature macro: MULTICYCLE_CONTROL_JUMP_EN enables the j instruction.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             MemWrite,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_e           state_q, state_d;
  logic [5:0]       opc_q, opc_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;   // this cycle completes an instruction
  logic             bad_op;   // DECODE saw an unsupported opcode

  // Next-state logic
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    retire  = 1'b0;
    bad_op  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opc_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      // Load/store split uses the latched opcode; the live input may already
      // carry the next instruction's bits.
      S_MEMADR:   state_d = (opc_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:    if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_RTYPE_WB: begin state_d = S_FETCH; retire = 1'b1; end
      S_BEQ:      begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  begin state_d = S_FETCH; retire = 1'b1; end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      S_JUMP:     begin state_d = S_FETCH; retire = 1'b1; end
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output decode: a function of state only, with mem_ready gating the
  // fetch write-enables and rst blanking every state-changing strobe.
  logic ir_w, pc_w, br, mem_w, reg_w;

  always_comb begin
    ir_w     = 1'b0;
    pc_w     = 1'b0;
    br       = 1'b0;
    mem_w    = 1'b0;
    reg_w    = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcB  = SRCB_REG;
    PCSrc    = PCSRC_ALU;
    ALUOp    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        ir_w    = mem_ready;
        pc_w    = mem_ready;
      end
      S_DECODE:   ALUSrcB = SRCB_BOFS;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD:    IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        reg_w    = 1'b1;
      end
      S_MEMWR: begin
        IorD  = 1'b1;
        mem_w = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        RegDst = 1'b1;
        reg_w  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_OUT;
        br      = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDI_WB:  reg_w = 1'b1;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        pc_w  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign IRWrite  = ir_w  & ~rst;
  assign PCWrite  = pc_w  & ~rst;
  assign Branch   = br    & ~rst;
  assign MemWrite = mem_w & ~rst;
  assign RegWrite = reg_w & ~rst;
  assign illegal  = bad_op & ~rst;
  assign retired  = retired_q;
  assign state    = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port opcode  in  6  instruction opcode, sampled in DECODE.
REQ-005 SHALL have port mem_ready  in  1  memory handshake, access completes in the cycle it is 1.
REQ-006 SHALL have ports IRWrite, PCWrite, Branch, MemWrite, IorD, ALUSrcA, RegDst, MemtoReg, RegWrite  out  1 each  datapath controls.
REQ-007 SHALL have ports ALUSrcB, PCSrc, ALUOp  out  2 each  datapath selects; ALUOp feeds the ALU control decoder (00 add, 01 sub, 10 funct).
REQ-008 SHALL have ports illegal  out  1  one-cycle pulse on unsupported opcode; retired  out  CNT_W  instructions completed; state  out  4  current state code, debug only.

Function
REQ-009 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ=8, ADDI_EX=9, ADDI_WB=10, JUMP=11.
REQ-010 SHALL drive every control to 0 unless this section lists it for the current state.
REQ-011 FETCH: ALUSrcB=01; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, go to DECODE when mem_ready=1.
REQ-012 DECODE: ALUSrcB=11; next state by opcode: 100011/101011->MEMADR, 000000->RTYPE_EX, 000100->BEQ, 001000->ADDI_EX, 000010->JUMP; any other->FETCH with illegal=1 for this cycle.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10; next MEMRD if latched opcode=100011, else MEMWR.
REQ-014 MEMRD: IorD=1; hold until mem_ready=1, then MEMWB.  MEMWB: MemtoReg=1, RegWrite=1; next FETCH.
REQ-015 MEMWR: IorD=1, MemWrite=1 held every cycle until mem_ready=1, then FETCH.
REQ-016 RTYPE_EX: ALUSrcA=1, ALUOp=10 -> RTYPE_WB: RegDst=1, RegWrite=1 -> FETCH.
REQ-017 BEQ: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
REQ-018 ADDI_EX: ALUSrcA=1, ALUSrcB=10 -> ADDI_WB: RegWrite=1 -> FETCH.
REQ-019 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-020 SHALL latch opcode into an internal register in DECODE; later states use the latched value, not the live input.
REQ-021 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR(mem_ready=1), RTYPE_WB, BEQ, ADDI_WB or JUMP; never on illegal; wraps modulo 2^CNT_W.
REQ-022 Cycle counts per instruction with zero memory wait: lw 5, sw 4, R 4, beq 3, addi 4, j 3.

Reset
REQ-023 rst=1 at a rising edge SHALL set state=FETCH, retired=0, latched opcode=0, overriding any transition, including mid-instruction or mid-handshake.
REQ-024 While rst=1, IRWrite, PCWrite, MemWrite, RegWrite, Branch and illegal SHALL be forced to 0 regardless of state or mem_ready.

Configuration
REQ-025 Macro MULTICYCLE_CONTROL_JUMP_EN: when defined, JUMP state and opcode 000010 SHALL be supported per REQ-012/019; when undefined, state 11 SHALL not exist and 000010 SHALL be treated as illegal.

Structure
REQ-026 State encodings, opcode constants and ALUOp codes SHALL live in shared package mips_ctrl_pkg, also used by the ALU control decoder.
REQ-027 SHALL be a single module; no sub-module needed; output decode SHALL be combinational from state (plus mem_ready/rst gating only).

Verification
REQ-028 Reset then opcode=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in state 7; ALUOp=10 in 6; retired=1.
REQ-029 lw (100011), mem_ready low 3 cycles in MEMRD -> IorD=1 for 4 cycles, MEMWB once, total 8 cycles, retired+1.
REQ-030 sw (101011), mem_ready=0 2 cycles in MEMWR -> MemWrite=1 for exactly 3 cycles, RegWrite never 1.
REQ-031 opcode=111111 in DECODE -> illegal=1 for one cycle, next state FETCH, retired unchanged.
REQ-032 rst=1 asserted in MEMWR with MemWrite=1 -> next cycle state=0, retired=0, MemWrite=0 during reset cycle.
REQ-033 opcode=000010 -> with JUMP_EN: PCSrc=10, PCWrite=1, 3 cycles, retired+1; without: illegal=1, retired unchanged.
